// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU / external-master RAM arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 9;
  localparam int unsigned RD_LATENCY_DEFAULT = 2;
  localparam int unsigned DATA_WIDTH         = 8;

  typedef enum logic [2:0] {
    ARB_RUN     = 3'd0,
    ARB_HALTING = 3'd1,
    ARB_OWNED   = 3'd2,
    ARB_XREAD   = 3'd3,
    ARB_XWRITE  = 3'd4,
    ARB_RESTART = 3'd5
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// External byte-master session and access port of the RAM arbiter.
interface mem_arbiter_if #(
  parameter int unsigned addr_width = mem_arbiter_pkg::ADDR_WIDTH_DEFAULT
) ();

  logic                  ext_session;
  logic                  ext_granted;
  logic                  ext_req;
  logic                  ext_we;
  logic [addr_width-1:0] ext_addr;
  logic [7:0]            ext_wdata;
  logic [7:0]            ext_rdata;
  logic                  ext_ack;
  logic [addr_width-1:0] run_address;

  modport master (
    output ext_session, ext_req, ext_we, ext_addr, ext_wdata, run_address,
    input  ext_granted, ext_rdata, ext_ack
  );

  modport slave (
    input  ext_session, ext_req, ext_we, ext_addr, ext_wdata, run_address,
    output ext_granted, ext_rdata, ext_ack
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the byte-wide SoC RAM between cpuv2 and an external byte master; halts the
// CPU for an external session and restarts it at a supplied address on release.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned addr_width = ADDR_WIDTH_DEFAULT,
  parameter int unsigned rd_latency = RD_LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width-1:0] cpu_raddr,
  input  logic [addr_width-1:0] cpu_waddr,
  input  logic [7:0]            cpu_wdata,
  input  logic                  cpu_write,
  output logic                  cpu_halt,
  input  logic                  cpu_halted,
  output logic                  cpu_reset,
  output logic [addr_width-1:0] cpu_start,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write,
  input  logic [7:0]            mem_data_out,
  mem_arbiter_if.slave          ext
);

  localparam int unsigned       CNT_W    = $clog2(rd_latency + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(rd_latency - 1);

  arb_state_e            state, state_nxt;
  logic                  halt_nxt;
  logic                  granted_r, granted_nxt;
  logic                  ack_r, ack_nxt;
  logic [7:0]            rdata_r, rdata_nxt;
  logic [addr_width-1:0] start_nxt;
  logic [addr_width-1:0] x_raddr, raddr_nxt;
  logic [addr_width-1:0] x_waddr, waddr_nxt;
  logic [7:0]            x_wdata, wdata_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;

  assign ext.ext_granted = granted_r;
  assign ext.ext_ack     = ack_r;
  assign ext.ext_rdata   = rdata_r;

  // Reset is also forwarded so the CPU restarts cleanly after a system reset.
  assign cpu_reset = reset | (state == ARB_RESTART);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_RUN;
      cpu_halt  <= 1'b0;
      granted_r <= 1'b0;
      ack_r     <= 1'b0;
      rdata_r   <= '0;
      cpu_start <= '0;
      x_raddr   <= '0;
      x_waddr   <= '0;
      x_wdata   <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      cpu_halt  <= halt_nxt;
      granted_r <= granted_nxt;
      ack_r     <= ack_nxt;
      rdata_r   <= rdata_nxt;
      cpu_start <= start_nxt;
      x_raddr   <= raddr_nxt;
      x_waddr   <= waddr_nxt;
      x_wdata   <= wdata_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_nxt   = state;
    halt_nxt    = cpu_halt;
    granted_nxt = granted_r;
    ack_nxt     = 1'b0;
    rdata_nxt   = rdata_r;
    start_nxt   = cpu_start;
    raddr_nxt   = x_raddr;
    waddr_nxt   = x_waddr;
    wdata_nxt   = x_wdata;
    cnt_nxt     = cnt;

    case (state)
      ARB_RUN: begin
        if (ext.ext_session) begin
          state_nxt = ARB_HALTING;
          halt_nxt  = 1'b1;
        end
      end

      // A session dropped here still goes through OWNED so the restart is clean.
      ARB_HALTING: begin
        if (cpu_halted) begin
          state_nxt   = ARB_OWNED;
          granted_nxt = 1'b1;
        end
      end

      // A pending access takes priority over a session release.
      ARB_OWNED: begin
        if (ext.ext_req) begin
          if (ext.ext_we) begin
            waddr_nxt = ext.ext_addr;
            wdata_nxt = ext.ext_wdata;
            ack_nxt   = 1'b1;
            state_nxt = ARB_XWRITE;
          end else begin
            raddr_nxt = ext.ext_addr;
            cnt_nxt   = '0;
            state_nxt = ARB_XREAD;
          end
        end else if (!ext.ext_session) begin
          start_nxt   = ext.run_address;
          halt_nxt    = 1'b0;
          granted_nxt = 1'b0;
          state_nxt   = ARB_RESTART;
        end
      end

      ARB_XREAD: begin
        if (cnt == CNT_LAST) begin
          rdata_nxt = mem_data_out;
          ack_nxt   = 1'b1;
          state_nxt = ARB_OWNED;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ARB_XWRITE:  state_nxt = ARB_OWNED;

      ARB_RESTART: state_nxt = ARB_RUN;

      default:     state_nxt = ARB_RUN;
    endcase
  end

  // RAM port mux: CPU passes straight through until it has halted.
  always_comb begin
    mem_raddr   = x_raddr;
    mem_waddr   = x_waddr;
    mem_data_in = x_wdata;
    mem_write   = (state == ARB_XWRITE);
    if (state == ARB_RUN || state == ARB_HALTING) begin
      mem_raddr   = cpu_raddr;
      mem_waddr   = cpu_waddr;
      mem_data_in = cpu_wdata;
      mem_write   = cpu_write;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: timeline reference model, RAM model and
// randomized CPU traffic / external sessions.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned AW    = 9;
  localparam int unsigned RDL   = 2;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } acc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] cpu_raddr, cpu_waddr, cpu_start, mem_raddr, mem_waddr;
  logic [7:0]    cpu_wdata, mem_data_in, mem_data_out;
  logic          cpu_write, cpu_halt, cpu_halted, cpu_reset, mem_write;

  mem_arbiter_if #(.addr_width(AW)) ext ();

  mem_arbiter #(.addr_width(AW), .rd_latency(RDL)) dut (
    .clk(clk), .reset(reset),
    .cpu_raddr(cpu_raddr), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_write(cpu_write), .cpu_halt(cpu_halt), .cpu_halted(cpu_halted),
    .cpu_reset(cpu_reset), .cpu_start(cpu_start),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_data_out(mem_data_out),
    .ext(ext)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // RAM: registered address, so read data is sampled RDL edges after the address.
  logic [7:0]    ram [DEPTH];
  logic [AW-1:0] raddr_q;
  logic          ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
    end else if (mem_write) begin
      ram[mem_waddr] <= mem_data_in;
    end
    raddr_q <= mem_raddr;
  end
  assign mem_data_out = ram[raddr_q];

  // Expected behaviour for the current cycle.
  logic          exp_halt, exp_granted, exp_ack, exp_creset, exp_cpu_path;
  logic          exp_mwrite, exp_wchk, exp_rchk;
  logic [7:0]    exp_rdata, exp_wdata;
  logic [AW-1:0] exp_start, exp_waddr, exp_raddr;
  logic [7:0]    shadow [DEPTH];
  bit            check_en;
  int            n_tests, n_fail;
  acc_t          accq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("cpu_halt",    32'(cpu_halt),        32'(exp_halt));
      chk("ext_granted", 32'(ext.ext_granted), 32'(exp_granted));
      chk("ext_ack",     32'(ext.ext_ack),     32'(exp_ack));
      chk("ext_rdata",   32'(ext.ext_rdata),   32'(exp_rdata));
      chk("cpu_reset",   32'(cpu_reset),       32'(exp_creset));
      chk("cpu_start",   32'(cpu_start),       32'(exp_start));
      if (exp_cpu_path) begin
        chk("mem_raddr_cpu",   32'(mem_raddr),   32'(cpu_raddr));
        chk("mem_waddr_cpu",   32'(mem_waddr),   32'(cpu_waddr));
        chk("mem_data_in_cpu", 32'(mem_data_in), 32'(cpu_wdata));
        chk("mem_write_cpu",   32'(mem_write),   32'(cpu_write));
      end else begin
        chk("mem_write_ext", 32'(mem_write), 32'(exp_mwrite));
        if (exp_wchk) begin
          chk("mem_waddr_ext",   32'(mem_waddr),   32'(exp_waddr));
          chk("mem_data_in_ext", 32'(mem_data_in), 32'(exp_wdata));
        end
        if (exp_rchk) chk("mem_raddr_ext", 32'(mem_raddr), 32'(exp_raddr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ext.ext_req = 1'b0;
    exp_ack     = 1'b0;
    exp_creset  = 1'b0;
    exp_mwrite  = 1'b0;
    exp_wchk    = 1'b0;
    exp_rchk    = 1'b0;
  endtask

  // Random CPU bus activity; tracked writes are those the RAM must actually see.
  task automatic cpu_random(input bit may_write, input bit tracked);
    cpu_raddr = AW'($urandom);
    cpu_waddr = AW'($urandom);
    cpu_wdata = 8'($urandom);
    cpu_write = may_write & 1'($urandom_range(0, 1));
    if (tracked && cpu_write) shadow[cpu_waddr] = cpu_wdata;
  endtask

  task automatic spurious();
    ext.ext_req   = 1'($urandom_range(0, 1));
    ext.ext_we    = 1'($urandom_range(0, 1));
    ext.ext_addr  = AW'($urandom);
    ext.ext_wdata = 8'($urandom);
  endtask

  task automatic run_phase(input int n);
    repeat (n) begin
      tick();
      cpu_random(1'b1, 1'b1);
      spurious();
    end
  endtask

  // One external session: request, halt handshake, queued accesses, release.
  task automatic session(input int halt_delay, input bit drop_in_halt, input bit drop_mid,
                         input bit reset_in_read, input logic [AW-1:0] run_addr);
    acc_t a;
    bit   last;
    tick();
    cpu_random(1'b1, 1'b1);
    ext.ext_session = 1'b1;
    for (int k = 1; k <= halt_delay; k++) begin
      tick();
      exp_halt = 1'b1;
      cpu_random(1'b0, 1'b1);
      spurious();
      cpu_halted = (k == halt_delay);
      if (drop_in_halt) ext.ext_session = 1'b0;
    end
    tick();
    exp_granted  = 1'b1;
    exp_cpu_path = 1'b0;
    cpu_random(1'b1, 1'b0);
    while (accq.size() > 0) begin
      a    = accq.pop_front();
      last = (accq.size() == 0);
      repeat ($urandom_range(0, 2)) begin
        tick();
        cpu_random(1'b1, 1'b0);
      end
      ext.ext_req   = 1'b1;
      ext.ext_we    = a.we;
      ext.ext_addr  = a.addr;
      ext.ext_wdata = a.data;
      if (a.we) begin
        tick();
        cpu_random(1'b1, 1'b0);
        spurious();
        if (drop_mid && last) ext.ext_session = 1'b0;
        exp_mwrite = 1'b1;
        exp_ack    = 1'b1;
        exp_wchk   = 1'b1;
        exp_waddr  = a.addr;
        exp_wdata  = a.data;
        shadow[a.addr] = a.data;
        tick();
        cpu_random(1'b1, 1'b0);
      end else begin
        for (int k = 0; k < RDL; k++) begin
          tick();
          cpu_random(1'b1, 1'b0);
          spurious();
          exp_rchk  = 1'b1;
          exp_raddr = a.addr;
          if (drop_mid && last) ext.ext_session = 1'b0;
          if (reset_in_read && last) begin
            reset      = 1'b1;
            exp_creset = 1'b1;
            #1;
            chk("t5_cpu_reset_in_reset", 32'(cpu_reset), 32'd1);
            tick();
            reset           = 1'b0;
            ext.ext_session = 1'b0;
            cpu_halted      = 1'b0;
            exp_halt        = 1'b0;
            exp_granted     = 1'b0;
            exp_rdata       = 8'h00;
            exp_start       = '0;
            exp_cpu_path    = 1'b1;
            cpu_random(1'b1, 1'b1);
            return;
          end
        end
        tick();
        cpu_random(1'b1, 1'b0);
        exp_ack   = 1'b1;
        exp_rdata = shadow[a.addr];
      end
    end
    ext.ext_session = 1'b0;
    ext.run_address = run_addr;
    tick();
    cpu_random(1'b1, 1'b0);
    spurious();
    exp_creset  = 1'b1;
    exp_halt    = 1'b0;
    exp_granted = 1'b0;
    exp_start   = run_addr;
    cpu_halted  = 1'b0;
    tick();
    cpu_random(1'b1, 1'b1);
    exp_cpu_path    = 1'b1;
    ext.run_address = AW'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    acc_t a;
    int   n_acc;
    bit   last_is_read;
    n_tests = 0; n_fail = 0; check_en = 1'b0;
    reset = 1'b1; ram_init = 1'b1;
    cpu_raddr = '0; cpu_waddr = '0; cpu_wdata = '0; cpu_write = 1'b0; cpu_halted = 1'b0;
    ext.ext_session = 1'b0; ext.ext_req = 1'b0; ext.ext_we = 1'b0;
    ext.ext_addr = '0; ext.ext_wdata = '0; ext.run_address = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
    exp_halt = 1'b0; exp_granted = 1'b0; exp_ack = 1'b0; exp_creset = 1'b1;
    exp_cpu_path = 1'b1; exp_mwrite = 1'b0; exp_wchk = 1'b0; exp_rchk = 1'b0;
    exp_rdata = 8'h00; exp_wdata = 8'h00; exp_start = '0; exp_waddr = '0; exp_raddr = '0;

    tick();
    exp_creset = 1'b1;
    check_en   = 1'b1;
    chk("rst_cpu_halt",    32'(cpu_halt),        32'd0);
    chk("rst_ext_granted", 32'(ext.ext_granted), 32'd0);
    chk("rst_cpu_reset",   32'(cpu_reset),       32'd1);
    tick();
    reset = 1'b0; ram_init = 1'b0;

    // CPU traffic mirrors straight through to the RAM in the same cycle
    cpu_raddr = 9'h055; cpu_waddr = 9'h010; cpu_wdata = 8'hA5; cpu_write = 1'b1;
    shadow[9'h010] = 8'hA5;
    #1;
    chk("t1_mem_raddr",   32'(mem_raddr),   32'h055);
    chk("t1_mem_waddr",   32'(mem_waddr),   32'h010);
    chk("t1_mem_data_in", 32'(mem_data_in), 32'h0A5);
    chk("t1_mem_write",   32'(mem_write),   32'd1);
    chk("t1_cpu_halt",    32'(cpu_halt),    32'd0);
    run_phase(3);

    // Write 0x3C @ 0x1FF, read it back, release during the read to 0x020
    accq.push_back('{we: 1'b1, addr: 9'h1FF, data: 8'h3C});
    accq.push_back('{we: 1'b0, addr: 9'h1FF, data: 8'h00});
    session(2, 1'b0, 1'b1, 1'b0, 9'h020);
    #1;
    chk("t3_ext_rdata",  32'(ext.ext_rdata), 32'h03C);
    chk("t4_cpu_start",  32'(cpu_start),     32'h020);
    chk("t4_cpu_halt",   32'(cpu_halt),      32'd0);
    run_phase(4);

    // Reset while a read is in flight
    accq.push_back('{we: 1'b0, addr: 9'h033, data: 8'h00});
    session(1, 1'b0, 1'b0, 1'b1, 9'h000);
    #1;
    chk("t5_ext_granted", 32'(ext.ext_granted), 32'd0);
    chk("t5_ext_ack",     32'(ext.ext_ack),     32'd0);
    chk("t5_ext_rdata",   32'(ext.ext_rdata),   32'd0);

    // Requests in RUN are ignored
    run_phase(20);

    // Session dropped while the CPU is still halting
    session(3, 1'b1, 1'b0, 1'b0, 9'h1A0);
    #1;
    chk("halt_drop_cpu_start", 32'(cpu_start), 32'h1A0);
    run_phase(2);

    repeat (40) begin
      run_phase($urandom_range(1, 8));
      n_acc = $urandom_range(0, 5);
      last_is_read = 1'b0;
      for (int i = 0; i < n_acc; i++) begin
        a.we   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0:       a.addr = AW'($urandom_range(0, 7));
          1:       a.addr = AW'(DEPTH - 1);
          default: a.addr = AW'($urandom);
        endcase
        a.data = 8'($urandom);
        last_is_read = !a.we;
        accq.push_back(a);
      end
      session($urandom_range(1, 4),
              (n_acc == 0) && ($urandom_range(0, 1) == 1),
              (n_acc > 0) && ($urandom_range(0, 2) == 0),
              last_is_read && ($urandom_range(0, 7) == 0),
              AW'($urandom));
    end
    run_phase(5);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
